// File: rtl/ram_rr_arbiter.sv
// ram_rr_arbiter: shares one single-port synchronous RAM between requesters A
// and B with round-robin arbitration, and can sweep the whole RAM to zero on
// a single-cycle clr_start pulse. Read data returns one cycle after the grant
// with a per-requester valid strobe.
module ram_rr_arbiter #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  // requester A
  input  logic             a_req,
  input  logic             a_we,
  input  logic [AW-1:0]    a_addr,
  input  logic [WIDTH-1:0] a_wdata,
  output logic             a_gnt,
  output logic             a_rvalid,
  output logic [WIDTH-1:0] a_rdata,
  // requester B
  input  logic             b_req,
  input  logic             b_we,
  input  logic [AW-1:0]    b_addr,
  input  logic [WIDTH-1:0] b_wdata,
  output logic             b_gnt,
  output logic             b_rvalid,
  output logic [WIDTH-1:0] b_rdata,
  // clear sweep control
  input  logic             clr_start,
  output logic             busy,
  // RAM side
  output logic             ram_wr_rd,
  output logic [AW-1:0]    ram_addr,
  output logic [WIDTH-1:0] ram_data_in,
  input  logic [WIDTH-1:0] ram_data_out
);

  typedef enum logic {
    ARB   = 1'b0,
    CLEAR = 1'b1
  } state_t;

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  state_t          state_reg;
  logic            ptr_reg;      // 0: A has priority on a tie, 1: B has priority
  logic [AW-1:0]   cnt_reg;      // sweep address
  logic            busy_reg;
  logic            a_rvalid_reg;
  logic            b_rvalid_reg;
  logic            arb_open;

  // Grants are only possible in ARB, out of reset, and not in a cycle that
  // starts a sweep (the sweep takes precedence over pending requests).
  assign arb_open = rst && (state_reg == ARB) && !clr_start;
  assign a_gnt    = arb_open && a_req && (!b_req || !ptr_reg);
  assign b_gnt    = arb_open && b_req && (!a_req ||  ptr_reg);

  assign busy     = busy_reg;
  assign a_rvalid = a_rvalid_reg;
  assign b_rvalid = b_rvalid_reg;

  // The RAM read port is registered, so the data word the RAM presents in the
  // cycle after a read grant is exactly the one the strobe qualifies.
  assign a_rdata  = ram_data_out;
  assign b_rdata  = ram_data_out;

  // RAM port mux: the sweep owns the RAM while clearing, otherwise the granted
  // requester drives it; an idle port is parked at address 0 with writes off.
  always_comb begin
    ram_wr_rd   = 1'b0;
    ram_addr    = '0;
    ram_data_in = '0;
    if (state_reg == CLEAR) begin
      ram_wr_rd   = 1'b1;
      ram_addr    = cnt_reg;
      ram_data_in = '0;
    end else if (a_gnt) begin
      ram_wr_rd   = a_we;
      ram_addr    = a_addr;
      ram_data_in = a_wdata;
    end else if (b_gnt) begin
      ram_wr_rd   = b_we;
      ram_addr    = b_addr;
      ram_data_in = b_wdata;
    end
  end

  // Control FSM: arbitration pointer, sweep counter, busy flag and read-valid
  // strobes. A read granted in the cycle before a sweep starts cannot exist
  // (clr_start blocks grants), but a read granted in the last ARB cycle still
  // gets its strobe because the strobes are updated in every state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= ARB;
      ptr_reg      <= 1'b0;
      cnt_reg      <= '0;
      busy_reg     <= 1'b0;
      a_rvalid_reg <= 1'b0;
      b_rvalid_reg <= 1'b0;
    end else begin
      a_rvalid_reg <= a_gnt && !a_we;
      b_rvalid_reg <= b_gnt && !b_we;
      case (state_reg)
        ARB: begin
          if (clr_start) begin
            state_reg <= CLEAR;
            busy_reg  <= 1'b1;
            cnt_reg   <= '0;
          end else if (a_gnt) begin
            ptr_reg <= 1'b1;
          end else if (b_gnt) begin
            ptr_reg <= 1'b0;
          end
        end
        CLEAR: begin
          if (cnt_reg == LAST_ADDR) begin
            state_reg <= ARB;
            busy_reg  <= 1'b0;
            cnt_reg   <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: begin
          state_reg <= ARB;
          busy_reg  <= 1'b0;
          cnt_reg   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_rr_arbiter.sv
// Testbench for ram_rr_arbiter: behavioural RAM on the RAM port, directed
// stimulus with hand-computed expectations, and a scoreboard monitor that
// checks read data and its arrival cycle whenever a valid strobe appears.
module tb_ram_rr_arbiter;

  localparam int DEPTH = 32;
  localparam int WIDTH = 8;
  localparam int AW    = 5;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             a_req = 1'b0, a_we = 1'b0;
  logic [AW-1:0]    a_addr = '0;
  logic [WIDTH-1:0] a_wdata = '0;
  logic             a_gnt, a_rvalid;
  logic [WIDTH-1:0] a_rdata;
  logic             b_req = 1'b0, b_we = 1'b0;
  logic [AW-1:0]    b_addr = '0;
  logic [WIDTH-1:0] b_wdata = '0;
  logic             b_gnt, b_rvalid;
  logic [WIDTH-1:0] b_rdata;
  logic             clr_start = 1'b0;
  logic             busy;
  logic             ram_wr_rd;
  logic [AW-1:0]    ram_addr;
  logic [WIDTH-1:0] ram_data_in;
  logic [WIDTH-1:0] ram_data_out;

  logic [WIDTH-1:0] mem [DEPTH];

  typedef struct {
    logic [WIDTH-1:0] data;
    int               due;
  } exp_t;

  exp_t a_q[$];
  exp_t b_q[$];

  int cyc    = 0;
  int passed = 0;
  int total  = 0;

  ram_rr_arbiter #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .clr_start(clr_start), .busy(busy),
    .ram_wr_rd(ram_wr_rd), .ram_addr(ram_addr),
    .ram_data_in(ram_data_in), .ram_data_out(ram_data_out)
  );

  always #5 clk = ~clk;

  // Single-port RAM, read-first, 1-cycle registered read.
  always @(posedge clk) begin
    if (ram_wr_rd) mem[ram_addr] <= ram_data_in;
    ram_data_out <= mem[ram_addr];
    cyc <= cyc + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    else passed++;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_a(input logic r, input logic we, input logic [AW-1:0] ad, input logic [WIDTH-1:0] d);
    a_req = r; a_we = we; a_addr = ad; a_wdata = d;
  endtask

  task automatic set_b(input logic r, input logic we, input logic [AW-1:0] ad, input logic [WIDTH-1:0] d);
    b_req = r; b_we = we; b_addr = ad; b_wdata = d;
  endtask

  task automatic push_a(input logic [WIDTH-1:0] d);
    exp_t e;
    e.data = d; e.due = cyc + 1;
    a_q.push_back(e);
  endtask

  task automatic push_b(input logic [WIDTH-1:0] d);
    exp_t e;
    e.data = d; e.due = cyc + 1;
    b_q.push_back(e);
  endtask

  // Scoreboard monitor: every valid strobe must match the oldest expected read.
  always @(negedge clk) begin
    if (rst) begin
      if (a_rvalid) begin
        if (a_q.size() == 0) chk("a_rvalid_unexpected", 32'(a_rvalid), 32'd0);
        else begin
          exp_t e;
          e = a_q.pop_front();
          chk("a_rdata", 32'(a_rdata), 32'(e.data));
          chk("a_rvalid_cycle", 32'(cyc), 32'(e.due));
        end
      end
      if (b_rvalid) begin
        if (b_q.size() == 0) chk("b_rvalid_unexpected", 32'(b_rvalid), 32'd0);
        else begin
          exp_t e;
          e = b_q.pop_front();
          chk("b_rdata", 32'(b_rdata), 32'(e.data));
          chk("b_rvalid_cycle", 32'(cyc), 32'(e.due));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // ---- reset state
    tick(); tick();
    set_a(1'b1, 1'b0, 5'd0, 8'h00);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_a_rvalid", 32'(a_rvalid), 32'd0);
    chk("rst_b_rvalid", 32'(b_rvalid), 32'd0);
    chk("rst_ram_wr_rd", 32'(ram_wr_rd), 32'd0);
    chk("rst_a_gnt", 32'(a_gnt), 32'd0);
    tick();
    rst = 1'b1;
    set_a(1'b0, 1'b0, 5'd0, 8'h00);

    // ---- 1: A writes 0xA5 to 12, A reads it back; B writes 0x5A to 3
    tick();
    set_a(1'b1, 1'b1, 5'd12, 8'hA5);
    #1;
    chk("t1_a_gnt_wr", 32'(a_gnt), 32'd1);
    chk("t1_b_gnt_wr", 32'(b_gnt), 32'd0);
    chk("t1_ram_wr_rd", 32'(ram_wr_rd), 32'd1);
    chk("t1_ram_addr", 32'(ram_addr), 32'd12);
    chk("t1_ram_data_in", 32'(ram_data_in), 32'hA5);
    tick();
    set_a(1'b1, 1'b0, 5'd12, 8'h00);
    #1;
    chk("t1_a_gnt_rd", 32'(a_gnt), 32'd1);
    chk("t1_ram_wr_rd_rd", 32'(ram_wr_rd), 32'd0);
    push_a(8'hA5);
    tick();
    set_a(1'b0, 1'b0, 5'd0, 8'h00);
    set_b(1'b1, 1'b1, 5'd3, 8'h5A);
    #1;
    chk("t1_b_gnt_wr", 32'(b_gnt), 32'd1);
    tick();
    set_b(1'b0, 1'b0, 5'd0, 8'h00);
    #1;
    chk("t1_idle_wr_rd", 32'(ram_wr_rd), 32'd0);
    chk("t1_idle_addr", 32'(ram_addr), 32'd0);

    // ---- 2: both read continuously; pointer favours A after B's write
    tick();
    set_a(1'b1, 1'b0, 5'd12, 8'h00);
    set_b(1'b1, 1'b0, 5'd3, 8'h00);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("t2_a_gnt", 32'(a_gnt), (k % 2 == 0) ? 32'd1 : 32'd0);
      chk("t2_b_gnt", 32'(b_gnt), (k % 2 == 1) ? 32'd1 : 32'd0);
      if (k % 2 == 0) push_a(8'hA5); else push_b(8'h5A);
      tick();
    end
    set_a(1'b0, 1'b0, 5'd0, 8'h00);
    set_b(1'b0, 1'b0, 5'd0, 8'h00);

    // ---- 3: A writes 0x3C to 5 while B reads 5
    tick();
    set_a(1'b1, 1'b1, 5'd5, 8'h3C);
    set_b(1'b1, 1'b0, 5'd5, 8'h00);
    #1;
    chk("t3_a_gnt", 32'(a_gnt), 32'd1);
    chk("t3_b_gnt_wait", 32'(b_gnt), 32'd0);
    tick();
    set_a(1'b0, 1'b0, 5'd0, 8'h00);
    #1;
    chk("t3_b_gnt", 32'(b_gnt), 32'd1);
    push_b(8'h3C);
    tick();
    set_b(1'b0, 1'b0, 5'd0, 8'h00);

    // ---- 4: fill RAM with nonzero data, then sweep
    for (int i = 0; i < DEPTH; i++) begin
      set_a(1'b1, 1'b1, AW'(i), 8'h80 | 8'(i));
      tick();
    end
    clr_start = 1'b1;
    set_a(1'b1, 1'b0, 5'd0, 8'h00);
    #1;
    chk("t4_gnt_at_start", 32'(a_gnt), 32'd0);
    tick();
    clr_start = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      chk("t4_busy", 32'(busy), 32'd1);
      #1;
      chk("t4_sweep_gnt", 32'(a_gnt), 32'd0);
      chk("t4_sweep_addr", 32'(ram_addr), 32'(i));
      chk("t4_sweep_we", 32'(ram_wr_rd), 32'd1);
      chk("t4_sweep_data", 32'(ram_data_in), 32'd0);
      tick();
    end
    chk("t4_busy_fall", 32'(busy), 32'd0);
    #1;
    chk("t4_gnt_after", 32'(a_gnt), 32'd1);
    push_a(8'h00);
    tick();
    set_a(1'b1, 1'b0, 5'd17, 8'h00);
    #1;
    chk("t4_gnt_17", 32'(a_gnt), 32'd1);
    push_a(8'h00);
    tick();
    set_a(1'b1, 1'b0, 5'd31, 8'h00);
    #1;
    chk("t4_gnt_31", 32'(a_gnt), 32'd1);
    push_a(8'h00);
    tick();
    set_a(1'b0, 1'b0, 5'd0, 8'h00);

    // ---- 5: reset aborts a sweep at sweep cycle 10
    tick();
    set_a(1'b1, 1'b1, 5'd9, 8'h99);
    tick();
    set_a(1'b1, 1'b1, 5'd20, 8'h42);
    tick();
    set_a(1'b0, 1'b0, 5'd0, 8'h00);
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    set_a(1'b1, 1'b0, 5'd0, 8'h00);
    for (int i = 0; i < 10; i++) tick();
    chk("t5_busy_before", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    chk("t5_busy_rst", 32'(busy), 32'd0);
    chk("t5_gnt_rst", 32'(a_gnt), 32'd0);
    chk("t5_rvalid_rst", 32'(a_rvalid), 32'd0);
    chk("t5_we_rst", 32'(ram_wr_rd), 32'd0);
    tick();
    rst = 1'b1;
    set_a(1'b1, 1'b0, 5'd9, 8'h00);
    #1;
    chk("t5_gnt_9", 32'(a_gnt), 32'd1);
    chk("t5_busy_after", 32'(busy), 32'd0);
    push_a(8'h00);
    tick();
    set_a(1'b1, 1'b0, 5'd20, 8'h00);
    #1;
    chk("t5_gnt_20", 32'(a_gnt), 32'd1);
    push_a(8'h42);
    tick();
    set_a(1'b0, 1'b0, 5'd0, 8'h00);

    // ---- 6: clr_start and a_req in the same cycle
    tick();
    clr_start = 1'b1;
    set_a(1'b1, 1'b0, 5'd20, 8'h00);
    #1;
    chk("t6_a_gnt_start", 32'(a_gnt), 32'd0);
    chk("t6_b_gnt_start", 32'(b_gnt), 32'd0);
    tick();
    clr_start = 1'b0;
    n = 0;
    while (busy && n < 40) begin
      #1;
      chk("t6_sweep_gnt", 32'(a_gnt), 32'd0);
      tick();
      n++;
    end
    chk("t6_sweep_len", 32'(n), 32'(DEPTH));
    #1;
    chk("t6_gnt_after", 32'(a_gnt), 32'd1);
    push_a(8'h00);
    tick();
    set_a(1'b0, 1'b0, 5'd0, 8'h00);
    tick(); tick(); tick();
    chk("a_queue_drained", 32'(a_q.size()), 32'd0);
    chk("b_queue_drained", 32'(b_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ram_rr_arbiter.md
Name: ram_rr_arbiter

Overview:
- Shares one single-port synchronous RAM between two requesters, A and B.
- Arbitration is round-robin. The block issues at most one RAM access per cycle and returns read data with a per-requester valid strobe.
- It also runs a software-triggered clear sweep that writes zero to every RAM location.
- It sits between the requesters and the RAM, and drives the RAM's address, data, write-enable and read-data path.

Parameters:
DEPTH, 32, number of RAM words; AW = $clog2(DEPTH)
WIDTH, 8, RAM word width in bits

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  asynchronous, active-low reset
a_req  in  1  requester A wants an access this cycle
a_we  in  1  A: 1 = write, 0 = read
a_addr  in  AW  A address
a_wdata  in  WIDTH  A write data
a_gnt  out  1  A access accepted at the coming edge (combinational)
a_rvalid  out  1  a_rdata is valid this cycle (registered)
a_rdata  out  WIDTH  read data for A
b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata  same as A, for requester B
clr_start  in  1  single-cycle pulse that starts the clear sweep
busy  out  1  high while the clear sweep is running
ram_wr_rd  out  1  RAM write enable (1 = write)
ram_addr  out  AW  RAM address
ram_data_in  out  WIDTH  RAM write data
ram_data_out  in  WIDTH  RAM registered read data (1-cycle latency)

Behaviour:
- Reset (rst low, asynchronous) forces:
  - FSM to ARB, with priority pointer favouring A;
  - clear counter to 0;
  - busy, a_rvalid, b_rvalid, ram_wr_rd to 0;
  - a_gnt and b_gnt to 0 while rst is low.
- The RAM holds its own contents across reset. Asserting reset during a sweep aborts it; locations not yet written keep their old contents.
- FSM states:
  - ARB: normal arbitration.
  - CLEAR: sweep in progress.
  - ARB -> CLEAR on clr_start = 1. clr_start takes precedence over pending requests in that cycle; no grant is issued that cycle.
  - CLEAR -> ARB after the write to address DEPTH-1.
  - clr_start is ignored while in CLEAR.
- ARB arbitration (combinational within the cycle):
  - Only one requester asserts req: it is granted.
  - Both assert req: grant the one the pointer favours.
  - On any grant, the pointer flips to favour the other requester at the edge.
  - No requests: no grant, pointer unchanged.
- Handshake:
  - An access is transferred at the posedge where x_req && x_gnt.
  - A requester must hold req, we, addr and wdata stable until granted.
  - A non-granted requester simply waits; there is no timeout.
- RAM drive:
  - Granted requester: ram_addr, ram_data_in and ram_wr_rd (= x_we) follow its inputs.
  - No grant: ram_wr_rd = 0, ram_addr = 0, ram_data_in = 0.
- Read return:
  - A read granted at edge t gives x_rvalid = 1 for exactly the cycle after t, with x_rdata = ram_data_out in that cycle.
  - x_rvalid is never asserted for writes.
  - x_rdata is don't-care when x_rvalid = 0.
  - Back-to-back grants to the same requester are only possible when the other requester is idle. Each read still returns its own rvalid on the following cycle.
- Ordering:
  - Accesses are serialised, so a read granted after a write to the same address returns the new data.
  - The RAM's read-during-write old data is never exposed, because rvalid is only raised for reads.
- CLEAR:
  - Every cycle: ram_wr_rd = 1, ram_addr = counter, ram_data_in = 0; counter increments.
  - The sweep takes exactly DEPTH cycles. busy = 1 for those DEPTH cycles and drops in the cycle FSM returns to ARB.
  - a_gnt = b_gnt = 0 throughout; requests stall.
  - The counter resets to 0 on exit.
  - A read granted in the last ARB cycle before CLEAR still returns its rvalid normally.

Test Plan:
1. Reset, then A writes 0xA5 to addr 12, then A reads addr 12 -> a_gnt=1 on each request cycle; a_rvalid=1 one cycle after the read grant with a_rdata=0xA5; b_rvalid stays 0.
2. A and B request reads simultaneously and continuously, both holding, pointer initially favouring A -> grants alternate A, B, A, B; each rvalid arrives exactly one cycle after its grant.
3. A writes 0x3C to addr 5 while B requests a read of addr 5 in the same cycle -> A is granted first, B the next cycle; b_rdata=0x3C.
4. Fill addrs 0..31 with nonzero data, pulse clr_start -> busy high for 32 cycles; requests during the sweep see gnt=0; afterwards reads of addrs 0, 17 and 31 return 0.
5. Start a sweep, assert rst low at sweep cycle 10 -> busy, rvalid and gnt go 0 immediately; after release, FSM is in ARB, addr 9 reads 0 and addr 20 keeps its pre-sweep value.
6. Pulse clr_start in the same cycle as a_req -> no grant that cycle; A is granted on the first cycle after busy falls.
